// File: rtl/pwm_deadtime_driver.sv
// Complementary high/low-side PWM driver with dead-band insertion and period-synchronous duty update.
// Optional duty slew limiting (soft start on every enable) is compiled in with PWM_SLEW_LIMIT_EN.
module pwm_deadtime_driver #(
    parameter int WIDTH     = 6,
    parameter int DEAD_TIME = 2,
    parameter int SLEW_STEP = 1
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             Enable_SW,
    input  logic [WIDTH-1:0] Duty_Input,
    output logic             PWM_H,
    output logic             PWM_L,
    output logic             Period_Start,
    output logic [WIDTH-1:0] Duty_Active
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HIGH = 2'd1,
        DEAD = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [3:0]       DT_LOAD = (DEAD_TIME > 0) ? 4'(DEAD_TIME - 1) : 4'd0;

    state_t           state_p0;
    state_t           state_nx;
    logic [3:0]       dt_cnt_p0;
    logic [3:0]       dt_cnt_nx;
    logic [WIDTH-1:0] cnt_p0;
    logic [WIDTH-1:0] shadow_p0;
    logic [WIDTH-1:0] next_duty;
    logic             raw;
    logic             pwm_h_p1;
    logic             pwm_l_p1;
    logic             period_start_p1;

`ifdef PWM_SLEW_LIMIT_EN
    localparam logic signed [WIDTH+1:0] STEP_S = (WIDTH + 2)'(SLEW_STEP);
    localparam logic signed [WIDTH+1:0] MAX_S  = (WIDTH + 2)'((1 << WIDTH) - 1);
    localparam logic signed [WIDTH+1:0] ZERO_S = '0;

    // Two guard bits keep current +/- step from wrapping before saturation.
    function automatic logic [WIDTH-1:0] slew_clamp(input logic [WIDTH-1:0] target,
                                                    input logic [WIDTH-1:0] current);
        logic signed [WIDTH+1:0] tgt;
        logic signed [WIDTH+1:0] lo;
        logic signed [WIDTH+1:0] hi;
        tgt = $signed({2'b00, target});
        lo  = $signed({2'b00, current}) - STEP_S;
        hi  = $signed({2'b00, current}) + STEP_S;
        if (lo < ZERO_S) lo = ZERO_S;
        if (hi > MAX_S) hi = MAX_S;
        if (tgt < lo) tgt = lo;
        else if (tgt > hi) tgt = hi;
        return tgt[WIDTH-1:0];
    endfunction

    assign next_duty = slew_clamp(Duty_Input, shadow_p0);
`else
    // SLEW_STEP has no effect without slew limiting.
    localparam int slew_step_unused = SLEW_STEP;

    assign next_duty = Duty_Input;
`endif

    // ---- stage p0: period counter and duty shadow register ----
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_p0          <= '0;
            shadow_p0       <= '0;
            period_start_p1 <= 1'b0;
        end else if (!Enable_SW) begin
            cnt_p0          <= '0;
`ifdef PWM_SLEW_LIMIT_EN
            shadow_p0       <= '0;
`else
            shadow_p0       <= next_duty;
`endif
            period_start_p1 <= 1'b0;
        end else begin
            cnt_p0          <= cnt_p0 + 1'b1;
            if (cnt_p0 == CNT_MAX) shadow_p0 <= next_duty;
            period_start_p1 <= (cnt_p0 == CNT_MAX);
        end
    end

    assign raw = (cnt_p0 < shadow_p0);

    always_comb begin
        state_nx  = state_p0;
        dt_cnt_nx = dt_cnt_p0;
        if (!Enable_SW) begin
            state_nx  = OFF;
            dt_cnt_nx = '0;
        end else begin
            unique case (state_p0)
                OFF: begin
                    if (DEAD_TIME == 0) begin
                        state_nx = raw ? HIGH : LOW;
                    end else begin
                        state_nx  = DEAD;
                        dt_cnt_nx = DT_LOAD;
                    end
                end
                HIGH: begin
                    if (!raw) begin
                        if (DEAD_TIME == 0) begin
                            state_nx = LOW;
                        end else begin
                            state_nx  = DEAD;
                            dt_cnt_nx = DT_LOAD;
                        end
                    end
                end
                LOW: begin
                    if (raw) begin
                        if (DEAD_TIME == 0) begin
                            state_nx = HIGH;
                        end else begin
                            state_nx  = DEAD;
                            dt_cnt_nx = DT_LOAD;
                        end
                    end
                end
                DEAD: begin
                    // Side is chosen at exit, so a pulse shorter than the band may return to the same side.
                    if (dt_cnt_p0 != 4'd0) begin
                        dt_cnt_nx = dt_cnt_p0 - 4'd1;
                    end else begin
                        state_nx = raw ? HIGH : LOW;
                    end
                end
                default: begin
                    state_nx  = OFF;
                    dt_cnt_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_p0  <= OFF;
            dt_cnt_p0 <= '0;
        end else begin
            state_p0  <= state_nx;
            dt_cnt_p0 <= dt_cnt_nx;
        end
    end

    // ---- stage p1: drive outputs registered from the next state so they track state exactly ----
    always_ff @(posedge sysclk) begin
        if (rst) begin
            pwm_h_p1 <= 1'b0;
            pwm_l_p1 <= 1'b0;
        end else begin
            pwm_h_p1 <= (state_nx == HIGH);
            pwm_l_p1 <= (state_nx == LOW);
        end
    end

    assign PWM_H        = pwm_h_p1;
    assign PWM_L        = pwm_l_p1;
    assign Period_Start = period_start_p1;
    assign Duty_Active  = shadow_p0;

endmodule
